seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_pkg.sv | 39 +++
 rtl/sat_counter.sv | 28 ++
 rtl/seq_detect_param.sv | 82 ++++++++
 tb/tb_seq_detect_param.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and elaboration-time helpers for the parameterised sequence detector.
package seq_pkg;

    localparam int MAX_W = 16;

    typedef logic [4:0] len_t;
    typedef len_t [MAX_W:0] border_tab_t;

    function automatic int state_w(input int pat_w);
        return $clog2(pat_w);
    endfunction

    // Bit j of the result is the j-th received bit of the pattern (MSB of pat first).
    function automatic logic [MAX_W:0] reverse_pat(input logic [MAX_W-1:0] pat, input int pat_w);
        logic [MAX_W:0] rev;
        rev = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < pat_w) rev[i] = pat[pat_w-1-i];
            else rev[i] = 1'b0;
        end
        return rev;
    endfunction

    // KMP failure table: entry k is the longest proper border of the k-bit prefix.
    function automatic border_tab_t border_table(input logic [MAX_W:0] rev, input int pat_w);
        border_tab_t tab;
        int k;
        tab = '0;
        k = 0;
        for (int i = 1; i < pat_w; i++) begin
            while (k > 0 && rev[i] != rev[k]) k = int'(tab[k]);
            if (rev[i] == rev[k]) k++;
            else k = k;
            tab[i+1] = len_t'(k);
        end
        return tab;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; sat flags the all-ones value.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_r;

    // Count register: clear wins, then increment only below the ceiling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_r <= '0;
        else if (clr) cnt_r <= '0;
        else if (inc && (cnt_r != CNT_MAX)) cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        else cnt_r <= cnt_r;
    end

    assign cnt = cnt_r;
    assign sat = (cnt_r == CNT_MAX);

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector: KMP-style matched-length state with one-cycle registered pulse.
module seq_detect_param
    import seq_pkg::*;
#(
    parameter int             PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1111,
    parameter int             OVERLAP = 1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             en,
    input  logic             clr,
    output logic             out,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam int               SW      = state_w(PAT_W);
    localparam logic [MAX_W-1:0] PAT_EXT = MAX_W'(PATTERN);
    localparam logic [MAX_W:0]   PAT_REV = reverse_pat(PAT_EXT, PAT_W);
    localparam border_tab_t      TAB     = border_table(PAT_REV, PAT_W);
    localparam len_t             BORDER  = TAB[PAT_W];
    localparam len_t             FULL    = len_t'(PAT_W);

    logic [SW-1:0] m_r;
    logic [SW-1:0] m_next_s;
    logic          out_r;
    len_t          k_s;
    len_t          ext_s;
    logic          hit_s;

    // State register: matched length and the registered detect pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_r   <= '0;
            out_r <= 1'b0;
        end else begin
            m_r   <= m_next_s;
            out_r <= hit_s;
        end
    end

    // Next state: fall back through the border table until in extends the prefix.
    always_comb begin
        k_s = len_t'(m_r);
        for (int i = 0; i < PAT_W; i++) begin
            if (k_s != 5'd0 && PAT_REV[k_s] != in) k_s = TAB[k_s];
            else k_s = k_s;
        end
        if (PAT_REV[k_s] == in) ext_s = k_s + 5'd1;
        else ext_s = k_s;

        m_next_s = m_r;
        if (clr) m_next_s = '0;
        else if (!en) m_next_s = m_r;
        else if (ext_s == FULL) m_next_s = (OVERLAP != 0) ? SW'(BORDER) : '0;
        else m_next_s = SW'(ext_s);
    end

    // Output: a full match on an accepted, non-cleared bit.
    always_comb begin
        hit_s = 1'b0;
        if (en && !clr && (ext_s == FULL)) hit_s = 1'b1;
        else hit_s = 1'b0;
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .inc(hit_s),
        .cnt(cnt),
        .sat(sat)
    );

    assign out = out_r;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param across several parameter sets sharing one stimulus bus.
module tb_seq_detect_param;

    logic clk;
    logic rst;
    logic in;
    logic en;
    logic clr;

    logic       o0, o1, o2, o3, o4;
    logic [7:0] c0, c1, c2, c3;
    logic [1:0] c4;
    logic       s0, s1, s2, s3, s4;

    int errors = 0;
    int checks = 0;

    seq_detect_param u0 (.clk(clk), .rst(rst), .in(in), .en(en), .clr(clr), .out(o0), .cnt(c0), .sat(s0));
    seq_detect_param #(.OVERLAP(0)) u1 (.clk(clk), .rst(rst), .in(in), .en(en), .clr(clr), .out(o1), .cnt(c1), .sat(s1));
    seq_detect_param #(.PATTERN(4'b1011), .OVERLAP(1)) u2 (.clk(clk), .rst(rst), .in(in), .en(en), .clr(clr), .out(o2), .cnt(c2), .sat(s2));
    seq_detect_param #(.PATTERN(4'b1011), .OVERLAP(0)) u3 (.clk(clk), .rst(rst), .in(in), .en(en), .clr(clr), .out(o3), .cnt(c3), .sat(s3));
    seq_detect_param #(.CNT_W(2)) u4 (.clk(clk), .rst(rst), .in(in), .en(en), .clr(clr), .out(o4), .cnt(c4), .sat(s4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic b, input logic e);
        in = b;
        en = e;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        in  = 1'b1;
        en  = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        logic [6:0] seq_a;
        logic [6:0] seq_b;
        seq_a = 7'b1011011;
        seq_b = 7'b1101111;
        rst = 1'b0;
        in  = 1'b0;
        en  = 1'b0;
        clr = 1'b0;

        #2;
        chk("rst_out", 32'(o0), 32'd0);
        chk("rst_cnt", 32'(c0), 32'd0);
        chk("rst_sat", 32'(s0), 32'd0);
        chk("rst_sat_w2", 32'(s4), 32'd0);
        #10;
        rst = 1'b1;

        // All-ones stream: overlapping, non-overlapping and 2-bit saturating counter.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1);
            chk("ones_ovl_out", 32'(o0), 32'(i >= 4));
            chk("ones_novl_out", 32'(o1), 32'((i == 4) || (i == 8)));
            if (i == 4) begin
                chk("w2_cnt_1", 32'(c4), 32'd1);
                chk("w2_sat_1", 32'(s4), 32'd0);
            end
            if (i == 6) begin
                chk("ones_ovl_cnt6", 32'(c0), 32'd3);
                chk("w2_cnt_3", 32'(c4), 32'd3);
                chk("w2_sat_3", 32'(s4), 32'd1);
            end
        end
        chk("ones_ovl_cnt8", 32'(c0), 32'd5);
        chk("ones_novl_cnt", 32'(c1), 32'd2);
        chk("w2_cnt_held", 32'(c4), 32'd3);
        chk("w2_sat_held", 32'(s4), 32'd1);

        // Clear on a would-be completing bit: no pulse, no count.
        do_clr();
        chk("clr_out", 32'(o0), 32'd0);
        chk("clr_cnt", 32'(c0), 32'd0);
        chk("clr_w2_cnt", 32'(c4), 32'd0);
        chk("clr_w2_sat", 32'(s4), 32'd0);

        // Pattern 1011 with and without overlap.
        for (int i = 0; i < 7; i++) begin
            step(seq_a[6-i], 1'b1);
            chk("p1011_ovl_out", 32'(o2), 32'((i == 3) || (i == 6)));
            chk("p1011_novl_out", 32'(o3), 32'(i == 3));
        end
        chk("p1011_ovl_cnt", 32'(c2), 32'd2);
        chk("p1011_novl_cnt", 32'(c3), 32'd1);
        do_clr();

        // 1101111 finds a single match at the last bit via fallback.
        for (int i = 0; i < 7; i++) begin
            step(seq_b[6-i], 1'b1);
            chk("fb_out", 32'(o0), 32'(i == 6));
        end
        chk("fb_cnt", 32'(c0), 32'd1);
        do_clr();

        // Same stream with idle en=0 cycles carrying the opposite bit.
        for (int i = 0; i < 7; i++) begin
            step(seq_b[6-i], 1'b1);
            chk("fb_en_out", 32'(o0), 32'(i == 6));
            step(~seq_b[6-i], 1'b0);
            chk("en0_out", 32'(o0), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            chk("en0_hold_out", 32'(o0), 32'd0);
        end
        chk("en0_hold_cnt", 32'(c0), 32'd1);
        chk("en0_w2_cnt", 32'(c4), 32'd1);

        // Partial match then asynchronous reset mid-cycle.
        step(1'b0, 1'b1);
        chk("pre_rst_zero", 32'(o0), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            chk("pre_rst_out", 32'(o0), 32'd0);
        end
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_out", 32'(o0), 32'd0);
        chk("async_rst_cnt", 32'(c0), 32'd0);
        chk("async_rst_w2_cnt", 32'(c4), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b1);
            chk("post_rst_out", 32'(o0), 32'(i == 4));
        end
        chk("post_rst_cnt", 32'(c0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
